// File: rtl/dbus_interconnect.sv
// dbus_interconnect: decodes the RV32i data port onto N wait-state slaves.
// Address, write data and byte lanes are broadcast to every slave. Only the
// decoded slave gets a re/we strobe. Its valid is returned to the core in the
// same cycle. Illegal or unmapped accesses get a one-cycle error response.
// Optional: define DBUS_TIMEOUT_EN to make a stuck BUSY end in an error
// response after TIMEOUT cycles.
module dbus_interconnect #(
    parameter int unsigned            N_SLAVES   = 2,
    parameter logic [N_SLAVES*32-1:0] BASE_ADDRS = {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SIZES      = {32'd4096, 32'd4096},
    parameter int unsigned            TIMEOUT    = 64,
    parameter logic [31:0]            ERR_DATA   = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic [31:0]              m_add_i,
    input  logic [31:0]              m_di_i,
    input  logic                     m_we_i,
    input  logic                     m_re_i,
    input  logic [3:0]               m_ble_i,
    output logic [31:0]              m_do_o,
    output logic                     m_valid_o,
    output logic                     m_err_o,
    output logic [31:0]              s_add_o,
    output logic [31:0]              s_di_o,
    output logic [3:0]               s_ble_o,
    output logic [N_SLAVES-1:0]      s_we_o,
    output logic [N_SLAVES-1:0]      s_re_o,
    input  logic [N_SLAVES*32-1:0]   s_do_i,
    input  logic [N_SLAVES-1:0]      s_valid_i
);

    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DONE} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_SLAVES-1:0] hit;
    logic [31:0]        s_do_a [N_SLAVES];
    logic [SEL_W-1:0]   hit_idx;
    logic               any_hit;
    logic               req;
    logic               illegal;

`ifdef DBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign s_add_o = m_add_i;
    assign s_di_o  = m_di_i;
    assign s_ble_o = m_ble_i;

    assign req     = m_re_i | m_we_i;
    assign illegal = m_re_i & m_we_i;

    // Per-region hit uses the offset form so a region ending at 4 GiB cannot
    // overflow the compare.
    for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
        localparam logic [31:0] BASE = BASE_ADDRS[k*32 +: 32];
        localparam logic [31:0] SIZE = SIZES[k*32 +: 32];
        assign hit[k]    = (m_add_i >= BASE) && ((m_add_i - BASE) < SIZE);
        assign s_do_a[k] = s_do_i[k*32 +: 32];
    end

    // Priority encoder: when regions overlap, the lowest index wins.
    always_comb begin
        hit_idx = '0;
        any_hit = |hit;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) hit_idx = SEL_W'(k);
        end
    end

    // State, selected slave and timeout counter registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
`ifdef DBUS_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Next-state logic: decode in IDLE, wait in BUSY, one-cycle ERR and DONE.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
`ifdef DBUS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (illegal || !any_hit) begin
                        state_d = ERR;
                    end else begin
                        sel_d   = hit_idx;
                        state_d = s_valid_i[hit_idx] ? DONE : BUSY;
`ifdef DBUS_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (s_valid_i[sel_q]) begin
                    state_d = DONE;
                end else begin
`ifdef DBUS_TIMEOUT_EN
                    if (tmo_cnt_q == TW'(TIMEOUT - 1)) state_d = ERR;
                    else tmo_cnt_d = tmo_cnt_q + TW'(1);
`endif
                end
            end
            ERR:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: strobes and response are combinational so a slave's valid
    // reaches the core with no added latency; reset forces everything low
    // immediately rather than waiting for the state register to settle.
    always_comb begin
        s_re_o    = '0;
        s_we_o    = '0;
        m_valid_o = 1'b0;
        m_err_o   = 1'b0;
        m_do_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (req && !illegal && any_hit) begin
                    s_re_o[hit_idx] = m_re_i;
                    s_we_o[hit_idx] = m_we_i;
                    if (s_valid_i[hit_idx]) begin
                        m_valid_o = 1'b1;
                        m_do_o    = s_do_a[hit_idx];
                    end
                end
            end
            BUSY: begin
                if (req) begin
                    s_re_o[sel_q] = m_re_i;
                    s_we_o[sel_q] = m_we_i;
                    if (s_valid_i[sel_q]) begin
                        m_valid_o = 1'b1;
                        m_do_o    = s_do_a[sel_q];
                    end
                end
            end
            ERR: begin
                m_valid_o = 1'b1;
                m_err_o   = 1'b1;
                m_do_o    = ERR_DATA;
            end
            default: ;
        endcase
        if (!resetn_i) begin
            s_re_o    = '0;
            s_we_o    = '0;
            m_valid_o = 1'b0;
            m_err_o   = 1'b0;
            m_do_o    = '0;
        end
    end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect: DUT A uses the default two-slave map
// with WS=3 memory models; DUT B has three slaves (0 and 1 overlapping) that
// answer with zero wait states.
module tb_dbus_interconnect;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    // ---------------- DUT A: default map ----------------
    logic [31:0] m_add = '0, m_di = '0;
    logic        m_we = 1'b0, m_re = 1'b0;
    logic [3:0]  m_ble = '0;
    logic [31:0] m_do, s_add, s_di;
    logic        m_valid, m_err;
    logic [3:0]  s_ble;
    logic [1:0]  s_we, s_re, s_valid;
    logic [63:0] s_do;
    logic [1:0]  hold = '0;

    dbus_interconnect #(.TIMEOUT(8)) u_a (
        .clk_i(clk), .resetn_i(rstn),
        .m_add_i(m_add), .m_di_i(m_di), .m_we_i(m_we), .m_re_i(m_re), .m_ble_i(m_ble),
        .m_do_o(m_do), .m_valid_o(m_valid), .m_err_o(m_err),
        .s_add_o(s_add), .s_di_o(s_di), .s_ble_o(s_ble),
        .s_we_o(s_we), .s_re_o(s_re), .s_do_i(s_do), .s_valid_i(s_valid)
    );

    // Wait-state memory slaves: valid once the strobe has been held 3 cycles.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    int          cnt  [2];

    for (genvar k = 0; k < 2; k++) begin : g_sv
        assign s_valid[k] = (s_re[k] | s_we[k]) && (cnt[k] >= 3) && !hold[k];
    end
    assign s_do = {mem1[s_add[11:2]], mem0[s_add[11:2]]};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) cnt[k] <= (s_re[k] | s_we[k]) ? cnt[k] + 1 : 0;
        if (s_we[0] && s_valid[0]) mem0[s_add[11:2]] <= s_di;
        if (s_we[1] && s_valid[1]) mem1[s_add[11:2]] <= s_di;
    end

    // ---------------- DUT B: three slaves, overlap ----------------
    logic [31:0] b_add = '0;
    logic        b_re = 1'b0;
    logic [31:0] b_do, b_sadd, b_sdi;
    logic        b_valid, b_err;
    logic [3:0]  b_sble;
    logic [2:0]  b_swe, b_sre;

    dbus_interconnect #(
        .N_SLAVES(3),
        .BASE_ADDRS({32'h0000_4000, 32'h0000_1000, 32'h0000_0000}),
        .SIZES({32'h0000_1000, 32'h0000_1000, 32'h0000_2000})
    ) u_b (
        .clk_i(clk), .resetn_i(rstn),
        .m_add_i(b_add), .m_di_i(32'h0), .m_we_i(1'b0), .m_re_i(b_re), .m_ble_i(4'hF),
        .m_do_o(b_do), .m_valid_o(b_valid), .m_err_o(b_err),
        .s_add_o(b_sadd), .s_di_o(b_sdi), .s_ble_o(b_sble),
        .s_we_o(b_swe), .s_re_o(b_sre),
        .s_do_i({32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000}),
        .s_valid_i(b_sre | b_swe)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++; if (m_valid !== 1'b0) begin miss++; $display("FAIL rst_valid got %b exp 0", m_valid); end
        vec++; if (m_err !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp 0", m_err); end
        vec++; if (m_do !== 32'h0) begin miss++; $display("FAIL rst_do got %h exp 0", m_do); end
        vec++; if ((s_re | s_we) !== 2'b00) begin miss++; $display("FAIL rst_strobe got %b exp 00", s_re | s_we); end
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_write_read();
        m_we = 1'b1; m_add = 32'h0001_0010; m_di = 32'hCAFE_F00D; m_ble = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (s_we !== 2'b10) begin miss++; $display("FAIL wr_strobe c%0d got %b exp 10", i, s_we); end
            vec++; if (m_valid !== 1'(i == 3)) begin miss++; $display("FAIL wr_valid c%0d got %b exp %b", i, m_valid, 1'(i == 3)); end
            if (i == 0) begin
                vec++; if ({s_add, s_di, s_ble} !== {32'h0001_0010, 32'hCAFE_F00D, 4'hF})
                    begin miss++; $display("FAIL bcast got %h %h %h", s_add, s_di, s_ble); end
            end
            if (i == 3) begin
                vec++; if (m_err !== 1'b0) begin miss++; $display("FAIL wr_err got %b exp 0", m_err); end
            end
            cyc();
        end
        // DONE with the core's trailing request still visible
        @(negedge clk);
        vec++; if ((s_we | s_re) !== 2'b00 || m_valid !== 1'b0)
            begin miss++; $display("FAIL wr_done strobe %b valid %b exp 00 0", s_we | s_re, m_valid); end
        cyc();
        // back-to-back read of the same word
        m_we = 1'b0; m_re = 1'b1; m_di = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (s_re !== 2'b10) begin miss++; $display("FAIL rd_strobe c%0d got %b exp 10", i, s_re); end
            vec++; if (m_valid !== 1'(i == 3)) begin miss++; $display("FAIL rd_valid c%0d got %b exp %b", i, m_valid, 1'(i == 3)); end
            if (i == 3) begin
                vec++; if (m_do !== 32'hCAFE_F00D) begin miss++; $display("FAIL rd_data got %h exp cafef00d", m_do); end
            end
            cyc();
        end
        @(negedge clk);
        vec++; if (s_re !== 2'b00) begin miss++; $display("FAIL rd_done strobe got %b exp 00", s_re); end
        cyc();
        m_re = 1'b0;
        cyc();
    endtask

    task automatic test_unmapped();
        m_re = 1'b1; m_add = 32'h0000_0FFC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (s_re !== 2'b01) begin miss++; $display("FAIL edge_strobe c%0d got %b exp 01", i, s_re); end
            if (i == 3) begin
                vec++; if (m_valid !== 1'b1 || m_do !== 32'h1234_5678)
                    begin miss++; $display("FAIL edge_data got %b %h exp 1 12345678", m_valid, m_do); end
            end
            cyc();
        end
        cyc();                      // DONE
        m_add = 32'h0000_1000;      // one past slave 0: unmapped
        @(negedge clk);
        vec++; if (s_re !== 2'b00 || m_valid !== 1'b0)
            begin miss++; $display("FAIL unmap_req strobe %b valid %b exp 00 0", s_re, m_valid); end
        cyc();
        @(negedge clk);
        vec++; if ({m_valid, m_err, m_do, s_re} !== {1'b1, 1'b1, 32'h0, 2'b00})
            begin miss++; $display("FAIL unmap_err got v%b e%b d%h s%b exp v1 e1 d0 s00", m_valid, m_err, m_do, s_re); end
        cyc();
        @(negedge clk);
        vec++; if (m_valid !== 1'b0 || m_err !== 1'b0) begin miss++; $display("FAIL unmap_done got v%b e%b exp 0 0", m_valid, m_err); end
        cyc();
        // very top of the address space, also unmapped
        m_add = 32'hFFFF_FFF0;
        cyc();
        @(negedge clk);
        vec++; if (m_valid !== 1'b1 || m_err !== 1'b1) begin miss++; $display("FAIL top_err got v%b e%b exp 1 1", m_valid, m_err); end
        cyc();
        m_re = 1'b0;
        cyc();
    endtask

    task automatic test_overlap();
        b_re = 1'b1; b_add = 32'h0000_1800;
        @(negedge clk);
        vec++; if (b_sre !== 3'b001) begin miss++; $display("FAIL ovl_strobe got %b exp 001", b_sre); end
        vec++; if ({b_valid, b_err, b_do} !== {1'b1, 1'b0, 32'hA0A0_0000})
            begin miss++; $display("FAIL ovl_resp got v%b e%b d%h exp v1 e0 a0a00000", b_valid, b_err, b_do); end
        cyc();
        @(negedge clk);
        vec++; if (b_sre !== 3'b000 || b_valid !== 1'b0) begin miss++; $display("FAIL ovl_done got %b %b exp 000 0", b_sre, b_valid); end
        cyc();
        b_add = 32'h0000_4010;
        @(negedge clk);
        vec++; if (b_sre !== 3'b100 || b_do !== 32'hA0A0_0002)
            begin miss++; $display("FAIL s2_resp got %b %h exp 100 a0a00002", b_sre, b_do); end
        cyc();
        b_re = 1'b0;
        cyc();
    endtask

    task automatic test_illegal();
        m_re = 1'b1; m_we = 1'b1; m_add = 32'h0000_0010;
        @(negedge clk);
        vec++; if ((s_re | s_we) !== 2'b00 || m_valid !== 1'b0)
            begin miss++; $display("FAIL ill_req strobe %b valid %b exp 00 0", s_re | s_we, m_valid); end
        cyc();
        @(negedge clk);
        vec++; if ({m_valid, m_err, m_do, s_re | s_we} !== {1'b1, 1'b1, 32'h0, 2'b00})
            begin miss++; $display("FAIL ill_err got v%b e%b d%h s%b exp v1 e1 d0 s00", m_valid, m_err, m_do, s_re | s_we); end
        cyc();
        m_re = 1'b0; m_we = 1'b0;
        cyc();
    endtask

    task automatic test_abort();
        m_re = 1'b1; m_add = 32'h0001_0010;
        @(negedge clk);
        vec++; if (s_re !== 2'b10) begin miss++; $display("FAIL ab_strobe got %b exp 10", s_re); end
        cyc();
        m_re = 1'b0;
        @(negedge clk);
        vec++; if (s_re !== 2'b00 || m_valid !== 1'b0) begin miss++; $display("FAIL ab_drop got %b %b exp 00 0", s_re, m_valid); end
        cyc();
        m_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (m_valid !== 1'(i == 3) || s_re !== 2'b10)
                begin miss++; $display("FAIL ab_retry c%0d got v%b s%b exp v%b s10", i, m_valid, s_re, 1'(i == 3)); end
            if (i == 3) begin
                vec++; if (m_do !== 32'hCAFE_F00D) begin miss++; $display("FAIL ab_data got %h exp cafef00d", m_do); end
            end
            cyc();
        end
        cyc();
        m_re = 1'b0;
        cyc();
    endtask

`ifdef DBUS_TIMEOUT_EN
    task automatic test_timeout();
        hold[1] = 1'b1; m_re = 1'b1; m_add = 32'h0001_0010;
        // cycle 0 is the IDLE request, cycles 1..8 are BUSY
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vec++; if (s_re !== 2'b10 || m_valid !== 1'b0)
                begin miss++; $display("FAIL tmo_wait c%0d got s%b v%b exp s10 v0", i, s_re, m_valid); end
            cyc();
        end
        @(negedge clk);
        vec++; if ({m_valid, m_err, m_do, s_re} !== {1'b1, 1'b1, 32'h0, 2'b00})
            begin miss++; $display("FAIL tmo_err got v%b e%b d%h s%b exp v1 e1 d0 s00", m_valid, m_err, m_do, s_re); end
        cyc();
        m_re = 1'b0; hold[1] = 1'b0;
        cyc();
    endtask
`else
    task automatic test_timeout();
        hold[1] = 1'b1; m_re = 1'b1; m_add = 32'h0001_0010;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vec++; if (s_re !== 2'b10 || m_valid !== 1'b0)
                begin miss++; $display("FAIL nowait c%0d got s%b v%b exp s10 v0", i, s_re, m_valid); end
            cyc();
        end
        hold[1] = 1'b0;
        @(negedge clk);
        vec++; if ({m_valid, m_err, m_do} !== {1'b1, 1'b0, 32'hCAFE_F00D})
            begin miss++; $display("FAIL nowait_resp got v%b e%b d%h exp v1 e0 cafef00d", m_valid, m_err, m_do); end
        cyc();
        cyc();
        m_re = 1'b0;
        cyc();
    endtask
`endif

    task automatic test_reset_mid();
        hold[1] = 1'b1; m_re = 1'b1; m_add = 32'h0001_0010;
        cyc();
        cyc();
        rstn = 1'b0;
        #1;
        vec++; if ({s_re, s_we, m_valid, m_err, m_do} !== {2'b00, 2'b00, 1'b0, 1'b0, 32'h0})
            begin miss++; $display("FAIL midrst got re%b we%b v%b e%b d%h exp all 0", s_re, s_we, m_valid, m_err, m_do); end
        cyc();
        m_re = 1'b0; hold[1] = 1'b0;
        rstn = 1'b1;
        cyc();
        m_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) begin
                vec++; if (m_valid !== 1'b1 || m_do !== 32'hCAFE_F00D)
                    begin miss++; $display("FAIL postrst got v%b d%h exp v1 cafef00d", m_valid, m_do); end
            end
            cyc();
        end
        cyc();
        m_re = 1'b0;
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[1023] = 32'h1234_5678;
        cnt[0] = 0;
        cnt[1] = 0;
        #2;
        test_reset();
        test_write_read();
        test_unmapped();
        test_overlap();
        test_illegal();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
